// File: rtl/serial_magnitude_comparator_if.sv
// Operand/result handshake bundle for serial_magnitude_comparator.
// The master side offers operands and consumes results; the slave side is the comparator.
interface serial_magnitude_comparator_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic             signed_in;
  logic             out_valid;
  logic             out_ready;
  logic             less_than;
  logic             equal_to;
  logic             greater_than;
  logic             busy;

  modport master (
    output in_valid, a_in, b_in, signed_in, out_ready,
    input  in_ready, out_valid, less_than, equal_to, greater_than, busy
  );

  modport slave (
    input  in_valid, a_in, b_in, signed_in, out_ready,
    output in_ready, out_valid, less_than, equal_to, greater_than, busy
  );
endinterface

// File: rtl/serial_magnitude_comparator.sv
// MSB-first serial magnitude comparator, DIGIT bits/cycle, unsigned or two's complement.
// Define EARLY_EXIT_EN to finish on the first differing digit instead of after all WIDTH/DIGIT cycles.
module serial_magnitude_comparator #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 1
) (
  input logic                          clk,
  input logic                          reset,
  serial_magnitude_comparator_if.slave bus
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = $clog2(N + 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [WIDTH-1:0] MSB_MASK = {1'b1, {(WIDTH-1){1'b0}}};

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             found_q, found_d;
  logic             lt_q, lt_d;
  logic             gt_q, gt_d;

  logic [DIGIT-1:0] dig_a;
  logic [DIGIT-1:0] dig_b;
  logic             dig_diff;

  assign dig_a    = a_q[WIDTH-1 -: DIGIT];
  assign dig_b    = b_q[WIDTH-1 -: DIGIT];
  assign dig_diff = (dig_a != dig_b);

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    cnt_d   = cnt_q;
    found_d = found_q;
    lt_d    = lt_q;
    gt_d    = gt_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          // Flipping the sign bit once at capture maps two's complement onto
          // offset binary, so every digit can then be compared unsigned.
          a_d     = bus.signed_in ? (bus.a_in ^ MSB_MASK) : bus.a_in;
          b_d     = bus.signed_in ? (bus.b_in ^ MSB_MASK) : bus.b_in;
          cnt_d   = CW'(N);
          found_d = 1'b0;
          lt_d    = 1'b0;
          gt_d    = 1'b0;
          state_d = RUN;
        end
      end
      RUN: begin
        if (!found_q && dig_diff) begin
          found_d = 1'b1;
          lt_d    = (dig_a < dig_b);
          gt_d    = (dig_a > dig_b);
        end
        a_d   = a_q << DIGIT;
        b_d   = b_q << DIGIT;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = DONE;
        end
`ifdef EARLY_EXIT_EN
        if (!found_q && dig_diff) begin
          state_d = DONE;
        end
`endif
      end
      DONE: begin
        if (bus.out_ready) begin
          found_d = 1'b0;
          lt_d    = 1'b0;
          gt_d    = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      cnt_q   <= '0;
      found_q <= 1'b0;
      lt_q    <= 1'b0;
      gt_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cnt_q   <= cnt_d;
      found_q <= found_d;
      lt_q    <= lt_d;
      gt_q    <= gt_d;
    end
  end

  // Flags are gated by DONE so they read zero whenever out_valid is low.
  assign bus.in_ready     = (state_q == IDLE);
  assign bus.busy         = (state_q != IDLE);
  assign bus.out_valid    = (state_q == DONE);
  assign bus.equal_to     = (state_q == DONE) && !found_q;
  assign bus.less_than    = (state_q == DONE) && lt_q;
  assign bus.greater_than = (state_q == DONE) && gt_q;

endmodule
